// File: rtl/shift_pkg.sv
// Shared definitions for the universal shift register: mode encodings, engine states
// and the shift-mode classifier.
package shift_pkg;

   localparam logic [2:0] MODE_HOLD = 3'b000;
   localparam logic [2:0] MODE_SHL  = 3'b001;
   localparam logic [2:0] MODE_SHR  = 3'b010;
   localparam logic [2:0] MODE_ROL  = 3'b011;
   localparam logic [2:0] MODE_ROR  = 3'b100;
   localparam logic [2:0] MODE_ASR  = 3'b101;
   localparam logic [2:0] MODE_LOAD = 3'b110;
   localparam logic [2:0] MODE_CLR  = 3'b111;

   typedef enum logic {IDLE, BUSY} state_t;

   function automatic logic is_shift_mode(input logic [2:0] m);
      return (m >= MODE_SHL) && (m <= MODE_ASR);
   endfunction

endpackage

// File: rtl/usr_cell.sv
// One bit of the universal register: async-reset flop behind an 8:1 next-value mux.
// Edge cells take the serial bit in place of the missing neighbour for logical shifts.
module usr_cell
   import shift_pkg::*;
#(
   parameter bit Lsb = 1'b0,
   parameter bit Msb = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [2:0] sel,
   input  logic       own,
   input  logic       left,
   input  logic       right,
   input  logic       dbit,
   input  logic       ser,
   output logic       q
);

   logic nxt;

   // left is bit i+1 and right is bit i-1, both wrapping, so rotates need no edge logic
   always_comb begin
      nxt = own;
      case (sel)
         MODE_HOLD: nxt = own;
         MODE_SHL:  nxt = Lsb ? ser : right;
         MODE_SHR:  nxt = Msb ? ser : left;
         MODE_ROL:  nxt = right;
         MODE_ROR:  nxt = left;
         MODE_ASR:  nxt = Msb ? own : left;
         MODE_LOAD: nxt = dbit;
         MODE_CLR:  nxt = 1'b0;
         default:   nxt = own;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= 1'b0;
      end else if (en) begin
         q <= nxt;
      end
   end

endmodule

// File: rtl/univ_shift_reg.sv
// N-bit universal register with a multi-cycle shift engine that applies a latched
// shift/rotate mode cnt times, one bit per enabled cycle, with busy/done handshake.
module univ_shift_reg
   import shift_pkg::*;
#(
   parameter int unsigned N  = 8,
   parameter int unsigned CW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic [2:0]    mode,
   input  logic [N-1:0]  d,
   input  logic          ser_lsb_in,
   input  logic          ser_msb_in,
   input  logic          start,
   input  logic [CW-1:0] cnt,
   output logic [N-1:0]  q,
   output logic          ser_msb_out,
   output logic          ser_lsb_out,
   output logic          busy,
   output logic          done
);

   state_t        state_q, state_d;
   logic [2:0]    mode_q, mode_d;
   logic [CW-1:0] count_q, count_d;
   logic          done_q, done_d;
   logic [2:0]    sel;

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      count_d = count_q;
      done_d  = done_q;
      sel     = MODE_HOLD;
      if (en) begin
         done_d = 1'b0;
         case (state_q)
            IDLE: begin
               // An accepted start only latches; q is untouched on the accepting edge
               if (start && is_shift_mode(mode)) begin
                  if (cnt == '0) begin
                     done_d = 1'b1;
                  end else begin
                     state_d = BUSY;
                     mode_d  = mode;
                     count_d = cnt;
                  end
               end else begin
                  sel = mode;
               end
            end
            BUSY: begin
               sel     = mode_q;
               count_d = count_q - 1'b1;
               if (count_q == CW'(1)) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         mode_q  <= MODE_HOLD;
         count_q <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         count_q <= count_d;
         done_q  <= done_d;
      end
   end

   for (genvar i = 0; i < N; i++) begin : g_cell
      usr_cell #(
         .Lsb(i == 0),
         .Msb(i == N - 1)
      ) u_cell (
         .clk  (clk),
         .rst  (rst),
         .en   (en),
         .sel  (sel),
         .own  (q[i]),
         .left (q[(i + 1) % N]),
         .right(q[(i + N - 1) % N]),
         .dbit (d[i]),
         .ser  ((i == 0) ? ser_lsb_in : ser_msb_in),
         .q    (q[i])
      );
   end

   assign ser_msb_out = q[N-1];
   assign ser_lsb_out = q[0];
   assign busy        = (state_q == BUSY);
   assign done        = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg (N=8, CW=4) with hand-computed expected values.
module tb_univ_shift_reg;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic [2:0] mode;
   logic [7:0] d;
   logic       ser_lsb_in;
   logic       ser_msb_in;
   logic       start;
   logic [3:0] cnt;
   logic [7:0] q;
   logic       ser_msb_out;
   logic       ser_lsb_out;
   logic       busy;
   logic       done;

   int n_checks = 0;
   int n_pass   = 0;
   int lat;

   univ_shift_reg #(
      .N (8),
      .CW(4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .mode       (mode),
      .d          (d),
      .ser_lsb_in (ser_lsb_in),
      .ser_msb_in (ser_msb_in),
      .start      (start),
      .cnt        (cnt),
      .q          (q),
      .ser_msb_out(ser_msb_out),
      .ser_lsb_out(ser_lsb_out),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic single(input logic [2:0] m, input logic [7:0] dv);
      mode = m;
      d    = dv;
      step();
      mode = 3'b000;
   endtask

   // Issue a start, then count enabled edges up to and including the one showing done.
   task automatic run_start(input logic [2:0] m, input logic [3:0] c, output int edges);
      mode  = m;
      cnt   = c;
      start = 1'b1;
      step();
      start = 1'b0;
      mode  = 3'b000;
      edges = 1;
      while (!done && edges < 40) begin
         step();
         edges++;
      end
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; mode = 3'b000; d = 8'h00;
      ser_lsb_in = 1'b0; ser_msb_in = 1'b0; start = 1'b0; cnt = 4'd0;
      #12;
      check("reset_q", q, 8'h00);
      check("reset_busy", busy, 1'b0);
      check("reset_done", done, 1'b0);
      rst = 1'b0;
      en  = 1'b1;

      single(3'b110, 8'hA5);
      check("load_q", q, 8'hA5);
      check("load_busy", busy, 1'b0);
      check("load_done", done, 1'b0);
      check("msb_out", ser_msb_out, 1'b1);
      check("lsb_out", ser_lsb_out, 1'b1);

      // ROL x3 from A5: 4B, 96, 2D
      mode = 3'b011; cnt = 4'd3; start = 1'b1;
      step();
      start = 1'b0; mode = 3'b000;
      check("rol_e0_q", q, 8'hA5);
      check("rol_e0_busy", busy, 1'b1);
      step();
      check("rol_e1_q", q, 8'h4B);
      check("rol_e1_busy", busy, 1'b1);
      step();
      check("rol_e2_q", q, 8'h96);
      check("rol_e2_done", done, 1'b0);
      step();
      check("rol_e3_q", q, 8'h2D);
      check("rol_e3_busy", busy, 1'b0);
      check("rol_e3_done", done, 1'b1);
      check("rol_msb_out", ser_msb_out, 1'b0);
      step();
      check("rol_done_clr", done, 1'b0);
      check("rol_hold_q", q, 8'h2D);

      single(3'b110, 8'h90);
      run_start(3'b101, 4'd2, lat);
      check("asr2_q", q, 8'hE4);
      check("asr2_lat", lat, 3);
      single(3'b110, 8'h90);
      run_start(3'b101, 4'd9, lat);
      check("asr9_q", q, 8'hFF);
      check("asr9_lat", lat, 10);

      // SHR x4 with serial 1, en dropped for two cycles mid-run
      single(3'b111, 8'h00);
      check("clr_q", q, 8'h00);
      ser_msb_in = 1'b1;
      mode = 3'b010; cnt = 4'd4; start = 1'b1;
      step();
      start = 1'b0; mode = 3'b000;
      step();
      check("shr_e1_q", q, 8'h80);
      step();
      check("shr_e2_q", q, 8'hC0);
      en = 1'b0;
      step();
      check("stall1_q", q, 8'hC0);
      check("stall1_busy", busy, 1'b1);
      step();
      check("stall2_q", q, 8'hC0);
      check("stall2_done", done, 1'b0);
      en = 1'b1;
      step();
      check("shr_e3_q", q, 8'hE0);
      check("shr_e3_done", done, 1'b0);
      step();
      check("shr_e4_q", q, 8'hF0);
      check("shr_e4_done", done, 1'b1);
      ser_msb_in = 1'b0;
      step();

      run_start(3'b001, 4'd0, lat);
      check("cnt0_lat", lat, 1);
      check("cnt0_q", q, 8'hF0);
      check("cnt0_busy", busy, 1'b0);

      // ROR x2 from F0 with a competing start held during BUSY: 78, 3C
      mode = 3'b100; cnt = 4'd2; start = 1'b1;
      step();
      mode = 3'b001; cnt = 4'd5;
      step();
      check("drop_e1_q", q, 8'h78);
      step();
      start = 1'b0; mode = 3'b000;
      check("drop_e2_q", q, 8'h3C);
      check("drop_e2_done", done, 1'b1);
      // New start accepted in the done cycle
      mode = 3'b011; cnt = 4'd1; start = 1'b1;
      step();
      start = 1'b0; mode = 3'b000;
      check("b2b_busy", busy, 1'b1);
      check("b2b_q", q, 8'h3C);
      step();
      check("b2b_q2", q, 8'h78);
      check("b2b_done", done, 1'b1);
      step();

      // Reset mid-run: SHL x5 from 78, reset in second BUSY cycle
      mode = 3'b001; cnt = 4'd5; start = 1'b1;
      step();
      start = 1'b0; mode = 3'b000;
      step();
      check("pre_rst_q", q, 8'hF0);
      rst = 1'b1;
      #1;
      check("rst_q", q, 8'h00);
      check("rst_busy", busy, 1'b0);
      rst = 1'b0;
      step();
      check("rst_no_done", done, 1'b0);
      check("rst_idle", busy, 1'b0);
      ser_lsb_in = 1'b1;
      single(3'b001, 8'h00);
      check("shl_ser_q", q, 8'h01);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
